// File: rtl/ssd_pkg.sv
// ssd_pkg: shared constants and helpers for the 7-segment display path.
//   SEG_W / SEG_OFF   : segment bus width and the all-off pattern
//   SEG_DIGIT_0..9    : active-high A..G patterns (bit 6 = A, bit 0 = G)
//   slot_state_t      : scan slot phase (BLANK / DRIVE)
//   pin_level()       : maps an active-high internal level to the pin level
package ssd_pkg;

    localparam int SEG_W = 7;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'b0000000;

    localparam logic [SEG_W-1:0] SEG_DIGIT_0 = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_DIGIT_1 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_DIGIT_2 = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_DIGIT_3 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_DIGIT_4 = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_DIGIT_5 = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_DIGIT_6 = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_DIGIT_7 = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_DIGIT_8 = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_DIGIT_9 = 7'b1111011;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } slot_state_t;

    // Internal logic is active-high; active_low = 1 flips the level at the pin.
    function automatic logic pin_level(input logic v, input logic active_low);
        return v ^ active_low;
    endfunction

endpackage

// File: rtl/ssd_scan_timer.sv
// ssd_scan_timer: slot counter, BLANK/DRIVE phase and digit index for the
// multiplexed display scan.
//   clk, rst        : clock, synchronous active-high reset
//   drive           : 1 while the current slot is in its DRIVE part
//   idx             : digit currently being scanned
//   frame_boundary  : 1 on the last cycle of the last digit slot
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   BLANK | slot counts 0..BLANK_CYCLES-1, all anodes held off
//   DRIVE | slot counts BLANK_CYCLES..SCAN_DIV-1, selected digit may light
module ssd_scan_timer
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000,
    localparam int CNT_W = $clog2(SCAN_DIV),
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             drive,
    output logic [IDX_W-1:0] idx,
    output logic             frame_boundary
);

    slot_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             slot_end;
    logic             last_digit;

    assign slot_end   = (cnt_q == CNT_W'(SCAN_DIV - 1));
    assign last_digit = (idx_q == IDX_W'(NUM_DIGITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;

        // The increment above would overflow only at the terminal count,
        // which is always overridden here.
        if (slot_end) begin
            cnt_d = '0;
            idx_d = last_digit ? '0 : idx_q + IDX_W'(1);
        end

        case (state_q)
            BLANK: if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) state_d = DRIVE;
            DRIVE: if (slot_end)                          state_d = BLANK;
            default:                                      state_d = BLANK;
        endcase
    end

    assign drive          = (state_q == DRIVE);
    assign idx            = idx_q;
    assign frame_boundary = slot_end && last_digit;

endmodule

// File: rtl/ssd_scan_controller.sv
// ssd_scan_controller: drives NUM_DIGITS common-anode digits over one shared
// segment bus, with anti-ghost blanking, per-digit enable, blink and a
// frame-synchronous double buffer.
//   clk, rst    : clock, synchronous active-high reset
//   seg_in      : digit k pattern at [7k+6:7k] (A..G, active-high)
//   dp_in       : decimal point per digit
//   digit_en    : digit k shown only when bit k = 1
//   blink_mask  : digit k blinks when bit k = 1
//   load        : 1-cycle strobe capturing the four inputs into staging
//   load_ack    : 1-cycle pulse when staging becomes the displayed data
//   seg_out     : shared segment bus (pin polarity per ACTIVE_LOW)
//   dp_out      : shared decimal point (pin polarity per ACTIVE_LOW)
//   an_out      : anode selects, one-hot or all off (pin polarity per ACTIVE_LOW)
//   frame_done  : 1-cycle pulse at the end of the last digit slot
module ssd_scan_controller
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_FRAMES = 64,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SEG_W*NUM_DIGITS-1:0] seg_in,
    input  logic [NUM_DIGITS-1:0]       dp_in,
    input  logic [NUM_DIGITS-1:0]       digit_en,
    input  logic [NUM_DIGITS-1:0]       blink_mask,
    input  logic                        load,
    output logic                        load_ack,
    output logic [SEG_W-1:0]            seg_out,
    output logic                        dp_out,
    output logic [NUM_DIGITS-1:0]       an_out,
    output logic                        frame_done
);

    localparam int   IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int   FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic POL   = (ACTIVE_LOW != 0);

    logic             drive;
    logic [IDX_W-1:0] idx;
    logic             frame_boundary;

    ssd_scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk            (clk),
        .rst            (rst),
        .drive          (drive),
        .idx            (idx),
        .frame_boundary (frame_boundary)
    );

    logic [SEG_W*NUM_DIGITS-1:0] stg_seg, sh_seg;
    logic [NUM_DIGITS-1:0]       stg_dp, sh_dp;
    logic [NUM_DIGITS-1:0]       stg_en, sh_en;
    logic [NUM_DIGITS-1:0]       stg_blink, sh_blink;
    logic                        pending;

    // Shadow is only written on the frame boundary. A load landing on the
    // boundary itself bypasses staging so it is not delayed a whole frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_seg   <= '0;
            stg_dp    <= '0;
            stg_en    <= '0;
            stg_blink <= '0;
            sh_seg    <= '0;
            sh_dp     <= '0;
            sh_en     <= '0;
            sh_blink  <= '0;
            pending   <= 1'b0;
        end else begin
            if (load) begin
                stg_seg   <= seg_in;
                stg_dp    <= dp_in;
                stg_en    <= digit_en;
                stg_blink <= blink_mask;
            end
            if (frame_boundary) begin
                pending <= 1'b0;
                if (load) begin
                    sh_seg   <= seg_in;
                    sh_dp    <= dp_in;
                    sh_en    <= digit_en;
                    sh_blink <= blink_mask;
                end else if (pending) begin
                    sh_seg   <= stg_seg;
                    sh_dp    <= stg_dp;
                    sh_en    <= stg_en;
                    sh_blink <= stg_blink;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    logic [FRM_W-1:0] frm_cnt;
    logic             blink_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            frm_cnt     <= '0;
            blink_phase <= 1'b0;
        end else if (frame_boundary) begin
            if (frm_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
                frm_cnt     <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frm_cnt <= frm_cnt + FRM_W'(1);
            end
        end
    end

    logic                  show;
    logic [SEG_W-1:0]      seg_next;
    logic                  dp_next;
    logic [NUM_DIGITS-1:0] an_next;

    // A disabled or blinked-off digit still consumes its slot with the
    // anodes off, so the lit digits keep a constant duty cycle.
    always_comb begin
        seg_next = SEG_OFF;
        dp_next  = 1'b0;
        an_next  = '0;
        show     = drive && sh_en[idx] && !(sh_blink[idx] && blink_phase);
        if (show) begin
            seg_next    = sh_seg[int'(idx)*SEG_W +: SEG_W];
            dp_next     = sh_dp[idx];
            an_next[idx] = 1'b1;
        end
    end

    logic [SEG_W-1:0]      seg_pin;
    logic                  dp_pin;
    logic [NUM_DIGITS-1:0] an_pin;

    always_comb begin
        seg_pin = '0;
        an_pin  = '0;
        for (int k = 0; k < SEG_W; k++) begin
            seg_pin[k] = pin_level(seg_next[k], POL);
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            an_pin[k] = pin_level(an_next[k], POL);
        end
        dp_pin = pin_level(dp_next, POL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_out    <= {SEG_W{POL}};
            dp_out     <= POL;
            an_out     <= {NUM_DIGITS{POL}};
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            seg_out    <= seg_pin;
            dp_out     <= dp_pin;
            an_out     <= an_pin;
            load_ack   <= frame_boundary && (load || pending);
            frame_done <= frame_boundary;
        end
    end

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Scoreboard bench for ssd_scan_controller (4 digits, 8-cycle slots, 2 blank
// cycles, 2-frame blink half-period, active-high pins). Stimulus pushes the
// expected anode runs, frame_done and load_ack cycles into queues; a negedge
// monitor pops and compares as the DUT produces them.
// cyc counts clock edges since reset release; outputs seen at cyc n reflect
// internal slot count (n-1) mod 8, so digit i of frame f is lit for cycles
// 32f+8i+3 .. 32f+8i+8 and frame_done / load_ack appear at multiples of 32.
module tb_ssd_scan_controller;

    localparam logic [6:0] P0 = 7'b1111110;
    localparam logic [6:0] P1 = 7'b0110000;
    localparam logic [6:0] P2 = 7'b1101101;
    localparam logic [6:0] P3 = 7'b1111001;
    localparam logic [6:0] P7 = 7'b1110000;
    localparam logic [6:0] P8 = 7'b1111111;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        int         start;
        int         len;
    } run_t;

    logic        clk;
    logic        rst;
    logic [27:0] seg_in;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic [3:0]  blink_mask;
    logic        load;
    logic        load_ack;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic        frame_done;

    int   cyc;
    int   n_checks;
    int   n_pass;
    logic mon_en;

    run_t exp_runs[$];
    int   exp_fd[$];
    int   exp_ack[$];

    ssd_scan_controller #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (8),
        .BLANK_CYCLES (2),
        .BLINK_FRAMES (2),
        .ACTIVE_LOW   (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .blink_mask (blink_mask),
        .load       (load),
        .load_ack   (load_ack),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .an_out     (an_out),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cyc %0d, t=%0t)", name, act, exp, cyc, $time);
    endtask

    // Monitor: tracks runs of a constant non-zero an_out and checks pulses.
    initial begin
        logic [3:0] cur_an;
        logic [6:0] run_seg;
        logic       run_dp;
        int         run_start;
        int         run_len;
        logic       run_stable;
        run_t       r;
        cur_an = '0; run_seg = '0; run_dp = 1'b0;
        run_start = 0; run_len = 0; run_stable = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (an_out != cur_an) begin
                    if (cur_an != 4'b0000) begin
                        if (exp_runs.size() == 0) begin
                            n_checks++;
                            $display("FAIL run_extra: an=%b seg=%b start=%0d len=%0d, no run expected",
                                     cur_an, run_seg, run_start, run_len);
                        end else begin
                            r = exp_runs.pop_front();
                            chk("run_an", int'(cur_an), int'(r.an));
                            chk("run_seg", int'(run_seg), int'(r.seg));
                            chk("run_dp", int'(run_dp), int'(r.dp));
                            chk("run_start", run_start, r.start);
                            chk("run_len", run_len, r.len);
                            chk("run_stable", int'(run_stable), 1);
                        end
                    end
                    cur_an     = an_out;
                    run_start  = cyc;
                    run_len    = 1;
                    run_seg    = seg_out;
                    run_dp     = dp_out;
                    run_stable = 1'b1;
                end else if (cur_an != 4'b0000) begin
                    run_len++;
                    if (seg_out != run_seg || dp_out != run_dp) run_stable = 1'b0;
                end
                if (frame_done) begin
                    if (exp_fd.size() == 0) begin
                        n_checks++;
                        $display("FAIL frame_done_extra: pulse at cyc %0d, none expected", cyc);
                    end else chk("frame_done_cyc", cyc, exp_fd.pop_front());
                end
                if (load_ack) begin
                    if (exp_ack.size() == 0) begin
                        n_checks++;
                        $display("FAIL load_ack_extra: pulse at cyc %0d, none expected", cyc);
                    end else chk("load_ack_cyc", cyc, exp_ack.pop_front());
                end
            end
        end
    end

    task automatic push_frame(input int f, input logic [3:0] en, input logic [27:0] segs,
                              input logic [3:0] dps);
        run_t r;
        for (int i = 0; i < 4; i++) begin
            if (en[i]) begin
                r.an    = 4'b0001 << i;
                r.seg   = segs[7*i +: 7];
                r.dp    = dps[i];
                r.start = 32*f + 8*i + 3;
                r.len   = 6;
                exp_runs.push_back(r);
            end
        end
    endtask

    task automatic push_fd(input int nframes);
        for (int f = 1; f <= nframes; f++) exp_fd.push_back(32*f);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
        chk("reset_an", int'(an_out), 0);
        chk("reset_seg", int'(seg_out), 0);
        chk("reset_dp", int'(dp_out), 0);
        chk("reset_load_ack", int'(load_ack), 0);
        chk("reset_frame_done", int'(frame_done), 0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc != n && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cyc != n) chk("wait_timeout", cyc, n);
    endtask

    // Called just after a clock edge; the strobe is sampled at the next edge.
    task automatic do_load(input logic [27:0] segs, input logic [3:0] dps,
                           input logic [3:0] en, input logic [3:0] blink);
        seg_in     = segs;
        dp_in      = dps;
        digit_en   = en;
        blink_mask = blink;
        load       = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic end_test(input int n);
        wait_cyc(n);
        @(negedge clk);
        #1;
        chk("runs_left", exp_runs.size(), 0);
        chk("frame_done_left", exp_fd.size(), 0);
        chk("load_ack_left", exp_ack.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        run_t tr;
        rst = 1'b1; load = 1'b0; mon_en = 1'b0;
        seg_in = '0; dp_in = '0; digit_en = '0; blink_mask = '0;
        n_checks = 0; n_pass = 0;

        // 1: all digits on, frames 1..3 lit after the load lands at cyc 32
        apply_reset();
        exp_ack.push_back(32);
        push_fd(4);
        for (int f = 1; f <= 3; f++) push_frame(f, 4'b1111, {4{P0}}, 4'b0101);
        do_load({4{P0}}, 4'b0101, 4'b1111, 4'b0000);
        end_test(129);

        // 2: digits 1 and 3 disabled
        apply_reset();
        exp_ack.push_back(32);
        push_fd(3);
        for (int f = 1; f <= 2; f++) push_frame(f, 4'b0101, {P3, P2, P1, P0}, 4'b1111);
        do_load({P3, P2, P1, P0}, 4'b1111, 4'b0101, 4'b0000);
        end_test(97);

        // 3: digit 0 blinks; phase 1 during frames 2 and 3
        apply_reset();
        exp_ack.push_back(32);
        push_fd(6);
        push_frame(1, 4'b1111, {P8, P7, P3, P1}, 4'b0000);
        push_frame(2, 4'b1110, {P8, P7, P3, P1}, 4'b0000);
        push_frame(3, 4'b1110, {P8, P7, P3, P1}, 4'b0000);
        push_frame(4, 4'b1111, {P8, P7, P3, P1}, 4'b0000);
        push_frame(5, 4'b1111, {P8, P7, P3, P1}, 4'b0000);
        do_load({P8, P7, P3, P1}, 4'b0000, 4'b1111, 4'b0001);
        end_test(193);

        // 4: two loads in one frame, last one wins, single ack
        apply_reset();
        exp_ack.push_back(32);
        push_fd(3);
        for (int f = 1; f <= 2; f++) push_frame(f, 4'b1111, {P7, P8, P3, P2}, 4'b1010);
        wait_cyc(5);
        do_load({4{P1}}, 4'b1111, 4'b1111, 4'b0000);
        wait_cyc(10);
        do_load({P7, P8, P3, P2}, 4'b1010, 4'b1111, 4'b0000);
        end_test(97);

        // 5: second load sampled on the boundary cycle, ack with frame_done at 64
        apply_reset();
        exp_ack.push_back(32);
        exp_ack.push_back(64);
        push_fd(3);
        push_frame(1, 4'b1111, {4{P8}}, 4'b0000);
        push_frame(2, 4'b1111, {P3, P2, P1, P0}, 4'b0011);
        wait_cyc(3);
        do_load({4{P8}}, 4'b0000, 4'b1111, 4'b0000);
        wait_cyc(63);
        do_load({P3, P2, P1, P0}, 4'b0011, 4'b1111, 4'b0000);
        end_test(97);

        // 6: reset during digit 2 DRIVE truncates its run; shadow cleared after
        apply_reset();
        exp_ack.push_back(32);
        exp_fd.push_back(32);
        push_frame(1, 4'b0011, {4{P2}}, 4'b0100);
        tr.an = 4'b0100; tr.seg = P2; tr.dp = 1'b1; tr.start = 51; tr.len = 3;
        exp_runs.push_back(tr);
        do_load({4{P2}}, 4'b0100, 4'b1111, 4'b0000);
        wait_cyc(53);
        exp_ack.push_back(96);
        push_fd(4);
        push_frame(3, 4'b1001, {P1, P3, P3, P7}, 4'b1000);
        apply_reset();
        wait_cyc(66);
        do_load({P1, P3, P3, P7}, 4'b1000, 4'b1001, 4'b0000);
        end_test(129);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
